// File: rtl/adc0808_responder.sv
// adc0808_responder
// Emulates an ADC0808-style successive-approximation converter: latches a
// channel address on ALE, arms on START rising, samples on START falling,
// then resolves one result bit every STEP_CYCLES clocks, MSB first.
module adc0808_responder #(
    parameter int unsigned STEP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ale,
    input  logic        start,
    input  logic        oe,
    input  logic [2:0]  addr,
    input  logic [63:0] ch_values,
    output logic        eoc,
    output logic [7:0]  data_out,
    output logic        data_en,
    output logic [2:0]  sel_ch
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CONVERT,
        DONE
    } state_t;

    localparam logic [7:0] STEP_LAST = 8'(STEP_CYCLES - 1);

    state_t     state;
    logic       ale_q;
    logic       start_q;
    logic [7:0] sar;
    logic [7:0] sample;
    logic [7:0] result;
    logic [7:0] step_cnt;
    logic [2:0] bit_idx;
    // Set once bit 0 has been decided; the following edge publishes the result.
    logic       finishing;

    logic       ale_rise;
    logic       start_rise;
    logic       start_fall;
    logic [2:0] conv_ch;
    logic [7:0] chosen_level;
    logic [7:0] trial;

    // Edge detection, channel choice and the trial value for the current bit.
    always_comb begin
        ale_rise   = ale & ~ale_q;
        start_rise = start & ~start_q;
        start_fall = ~start & start_q;
        // An address latched on this very edge takes precedence over the old one.
        conv_ch      = ale_rise ? addr : sel_ch;
        chosen_level = ch_values[{conv_ch, 3'b000} +: 8];
        trial        = sar | (8'h01 << bit_idx);
    end

    // Conversion control: address latch, arm/abort, sampling and SAR stepping.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state     <= IDLE;
            ale_q     <= 1'b0;
            start_q   <= 1'b0;
            sel_ch    <= 3'd0;
            sar       <= 8'h00;
            sample    <= 8'h00;
            result    <= 8'h00;
            step_cnt  <= 8'h00;
            bit_idx   <= 3'd0;
            finishing <= 1'b0;
            eoc       <= 1'b1;
        end else begin
            ale_q   <= ale;
            start_q <= start;

            if (ale_rise) begin
                sel_ch <= addr;
            end

            if (start_rise) begin
                // Arm, or abort whatever was in flight; result is left intact.
                state     <= ARMED;
                sar       <= 8'h00;
                eoc       <= 1'b0;
                step_cnt  <= 8'h00;
                finishing <= 1'b0;
            end else begin
                case (state)
                    ARMED: begin
                        if (start_fall) begin
                            sample   <= chosen_level;
                            state    <= CONVERT;
                            bit_idx  <= 3'd7;
                            step_cnt <= 8'h00;
                        end
                    end
                    CONVERT: begin
                        if (finishing) begin
                            result    <= sar;
                            eoc       <= 1'b1;
                            state     <= DONE;
                            finishing <= 1'b0;
                        end else if (step_cnt == STEP_LAST) begin
                            step_cnt <= 8'h00;
                            if (sample >= trial) begin
                                sar <= trial;
                            end
                            bit_idx <= bit_idx - 3'd1;
                            if (bit_idx == 3'd0) begin
                                finishing <= 1'b1;
                            end
                        end else begin
                            step_cnt <= step_cnt + 8'h01;
                        end
                    end
                    default: begin
                        // IDLE and DONE wait for the next START rise.
                    end
                endcase
            end
        end
    end

    // Read path: one-cycle registered bus drive following oe.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_en  <= 1'b0;
            data_out <= 8'h00;
        end else begin
            data_en  <= oe;
            data_out <= oe ? result : 8'h00;
        end
    end

endmodule

// File: tb/tb_adc0808_responder.sv
// tb_adc0808_responder
// Drives conversions on the ADC0808 responder and checks timing, sampled
// values and the read path against a behavioural expectation: a conversion
// returns exactly the level present on the chosen channel at the START fall,
// 8*STEP_CYCLES+1 clocks after that fall.
module tb_adc0808_responder;

    localparam int STEP    = 8;
    localparam int LATENCY = 8 * STEP + 1;
    localparam int BOUND   = 500;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ale = 1'b0;
    logic        start = 1'b0;
    logic        oe = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [63:0] ch_values = 64'h0;
    logic        eoc;
    logic [7:0]  data_out;
    logic        data_en;
    logic [2:0]  sel_ch;

    int n_checks = 0;
    int n_fail   = 0;

    adc0808_responder #(.STEP_CYCLES(STEP)) dut (
        .clk       (clk),
        .reset     (reset),
        .ale       (ale),
        .start     (start),
        .oe        (oe),
        .addr      (addr),
        .ch_values (ch_values),
        .eoc       (eoc),
        .data_out  (data_out),
        .data_en   (data_en),
        .sel_ch    (sel_ch)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int n, input logic [7:0] v);
        ch_values[n*8 +: 8] = v;
    endtask

    function automatic logic [7:0] level_of(input logic [63:0] vals, input int n);
        logic [63:0] tmp;
        tmp = vals >> (n * 8);
        return tmp[7:0];
    endfunction

    task automatic pulse_ale(input logic [2:0] a);
        ale  = 1'b1;
        addr = a;
        tick();
        ale  = 1'b0;
    endtask

    // One-cycle START pulse; returns just after the fall edge F.
    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    // Count clocks after F until eoc rises, starting from an already elapsed count.
    task automatic wait_eoc(input int already, output int cycles);
        cycles = already;
        while (eoc !== 1'b1 && cycles < BOUND) begin
            tick();
            cycles++;
        end
    endtask

    task automatic read_result(output logic [7:0] d, output logic en);
        oe = 1'b1;
        tick();
        d  = data_out;
        en = data_en;
        oe = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ale = 1'b0; start = 1'b0; oe = 1'b0; addr = 3'd0;
        tick();
        tick();
        n_checks++;
        if (eoc !== 1'b1) begin n_fail++; $display("FAIL reset_eoc: got %b expected 1", eoc); end
        n_checks++;
        if (data_en !== 1'b0) begin n_fail++; $display("FAIL reset_data_en: got %b expected 0", data_en); end
        n_checks++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        n_checks++;
        if (sel_ch !== 3'd0) begin n_fail++; $display("FAIL reset_sel_ch: got %0d expected 0", sel_ch); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int cycles;
        logic [7:0] d;
        logic en;
        set_ch(3, 8'hA5);
        pulse_ale(3'd3);
        n_checks++;
        if (sel_ch !== 3'd3) begin n_fail++; $display("FAIL basic_sel_ch: got %0d expected 3", sel_ch); end
        start = 1'b1;
        tick();
        n_checks++;
        if (eoc !== 1'b0) begin n_fail++; $display("FAIL basic_eoc_after_rise: got %b expected 0", eoc); end
        start = 1'b0;
        tick();
        wait_eoc(0, cycles);
        n_checks++;
        if (cycles != LATENCY) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", cycles, LATENCY); end
        read_result(d, en);
        n_checks++;
        if (en !== 1'b1) begin n_fail++; $display("FAIL basic_data_en: got %b expected 1", en); end
        n_checks++;
        if (d !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h expected a5", d); end
    endtask

    task automatic test_abort();
        int cycles;
        logic [7:0] d;
        logic en;
        logic early_bad;
        set_ch(3, 8'h11);
        start_pulse();
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (eoc !== 1'b0) begin n_fail++; $display("FAIL abort_eoc_first: got %b expected 0", eoc); end
        set_ch(3, 8'h3C);
        start = 1'b1;
        tick();
        n_checks++;
        if (eoc !== 1'b0) begin n_fail++; $display("FAIL abort_eoc_rearm: got %b expected 0", eoc); end
        start = 1'b0;
        oe = 1'b1;
        tick();
        // Prior result must stay readable while the restarted conversion runs.
        cycles = 0;
        early_bad = 1'b0;
        while (eoc !== 1'b1 && cycles < BOUND) begin
            tick();
            cycles++;
            if (eoc === 1'b0 && data_out !== 8'hA5 && !early_bad) begin
                early_bad = 1'b1;
                n_checks++;
                n_fail++;
                $display("FAIL abort_prior_result: got %h expected a5 at cycle %0d", data_out, cycles);
            end
        end
        n_checks++;
        if (cycles != LATENCY) begin n_fail++; $display("FAIL abort_latency: got %0d expected %0d", cycles, LATENCY); end
        oe = 1'b0;
        tick();
        read_result(d, en);
        n_checks++;
        if (d !== 8'h3C) begin n_fail++; $display("FAIL abort_result: got %h expected 3c", d); end
    endtask

    task automatic test_sample_hold();
        int cycles;
        logic [7:0] d;
        logic en;
        set_ch(3, 8'h55);
        pulse_ale(3'd3);
        start_pulse();
        tick(); tick(); tick();
        set_ch(3, 8'hAA);
        pulse_ale(3'd5);
        set_ch(5, 8'hF0);
        wait_eoc(4, cycles);
        n_checks++;
        if (cycles != LATENCY) begin n_fail++; $display("FAIL hold_latency: got %0d expected %0d", cycles, LATENCY); end
        n_checks++;
        if (sel_ch !== 3'd5) begin n_fail++; $display("FAIL hold_sel_ch: got %0d expected 5", sel_ch); end
        read_result(d, en);
        n_checks++;
        if (d !== 8'h55) begin n_fail++; $display("FAIL hold_result: got %h expected 55", d); end
    endtask

    task automatic test_boundaries();
        int         chans[4] = '{0, 7, 1, 1};
        logic [7:0] vals[4]  = '{8'h00, 8'hFF, 8'h80, 8'h7F};
        int cycles;
        logic [7:0] d;
        logic en;
        for (int i = 0; i < 4; i++) begin
            set_ch(chans[i], vals[i]);
            pulse_ale(3'(chans[i]));
            start_pulse();
            wait_eoc(0, cycles);
            n_checks++;
            if (cycles != LATENCY) begin n_fail++; $display("FAIL bound_latency[%0d]: got %0d expected %0d", i, cycles, LATENCY); end
            read_result(d, en);
            n_checks++;
            if (d !== vals[i]) begin n_fail++; $display("FAIL bound_result[%0d]: got %h expected %h", i, d, vals[i]); end
        end
    endtask

    task automatic test_random();
        int cycles;
        int ch;
        int ch_new;
        bit ale_at_fall;
        logic [7:0] expected;
        logic [7:0] d;
        logic en;
        for (int i = 0; i < 20; i++) begin
            ch_values   = {$urandom(), $urandom()};
            ch          = $urandom_range(0, 7);
            ch_new      = $urandom_range(0, 7);
            ale_at_fall = ($urandom_range(0, 2) == 0);
            pulse_ale(3'(ch));
            start = 1'b1;
            tick();
            start = 1'b0;
            if (ale_at_fall) begin
                ale  = 1'b1;
                addr = 3'(ch_new);
                ch   = ch_new;
            end
            expected = level_of(ch_values, ch);
            tick();
            ale = 1'b0;
            ch_values = {$urandom(), $urandom()};
            wait_eoc(0, cycles);
            n_checks++;
            if (cycles != LATENCY) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, cycles, LATENCY); end
            n_checks++;
            if (sel_ch !== 3'(ch)) begin n_fail++; $display("FAIL rand_sel_ch[%0d]: got %0d expected %0d", i, sel_ch, ch); end
            read_result(d, en);
            n_checks++;
            if (d !== expected) begin n_fail++; $display("FAIL rand_result[%0d]: got %h expected %h", i, d, expected); end
        end
    endtask

    task automatic test_reset_mid();
        int cycles;
        logic [7:0] d;
        logic en;
        set_ch(2, 8'hC3);
        pulse_ale(3'd2);
        start_pulse();
        wait_eoc(0, cycles);
        set_ch(2, 8'h5A);
        start_pulse();
        for (int i = 0; i < 30; i++) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (eoc !== 1'b1) begin n_fail++; $display("FAIL midreset_eoc: got %b expected 1", eoc); end
        n_checks++;
        if (sel_ch !== 3'd0) begin n_fail++; $display("FAIL midreset_sel_ch: got %0d expected 0", sel_ch); end
        reset = 1'b0;
        read_result(d, en);
        n_checks++;
        if (en !== 1'b1) begin n_fail++; $display("FAIL midreset_data_en: got %b expected 1", en); end
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL midreset_result: got %h expected 00", d); end
        for (int i = 0; i < 100; i++) tick();
        n_checks++;
        if (eoc !== 1'b1) begin n_fail++; $display("FAIL midreset_no_resume: got %b expected 1", eoc); end
        read_result(d, en);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL midreset_no_partial: got %h expected 00", d); end
    endtask

    task automatic test_reset_release();
        int cycles;
        logic [7:0] d;
        logic en;
        set_ch(0, 8'h9E);
        start = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (eoc !== 1'b0) begin n_fail++; $display("FAIL release_rise_eoc: got %b expected 0", eoc); end
        start = 1'b0;
        tick();
        wait_eoc(0, cycles);
        n_checks++;
        if (cycles != LATENCY) begin n_fail++; $display("FAIL release_latency: got %0d expected %0d", cycles, LATENCY); end
        read_result(d, en);
        n_checks++;
        if (d !== 8'h9E) begin n_fail++; $display("FAIL release_result: got %h expected 9e", d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_sample_hold();
        test_boundaries();
        test_random();
        test_reset_mid();
        test_reset_release();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc0808_responder.md
ADC0808_RESPONDER -- requirements
Module: adc0808_responder

Interface
REQ-001 Parameter STEP_CYCLES, default 8: clocks spent per SAR bit decision (legal 1..255).
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ale  in  1  address latch enable from initiator; rising edge latches addr.
REQ-005 start  in  1  conversion start; rising edge arms/aborts, falling edge starts conversion.
REQ-006 oe  in  1  output enable; high requests result on data_out.
REQ-007 addr  in  3  analog channel select.
REQ-008 ch_values  in  64  emulated analog levels; channel n at bits [8n+7:8n].
REQ-009 eoc  out  1  end of conversion; high = idle/done, low = converting.
REQ-010 data_out  out  8  conversion result while data_en high, else 8'h00.
REQ-011 data_en  out  1  tristate drive enable for data bus, mirrors oe.
REQ-012 sel_ch  out  3  currently latched channel address.

Function
REQ-013 All inputs are synchronous to clk; edges are detected against one-cycle registered copies of ale, start, oe.
REQ-014 ALE rising edge (ale=1, ale_q=0) shall load sel_ch <= addr on that clock edge, in any state.
REQ-015 States: IDLE, ARMED, CONVERT, DONE; DONE behaves as IDLE except result is valid.
REQ-016 START rising edge in any state: state <= ARMED, sar <= 0, eoc <= 0 on that edge; an in-progress conversion is aborted, result register unchanged.
REQ-017 START falling edge in ARMED (cycle F): sample <= ch_values[channel], state <= CONVERT, bit index <= 7, step counter <= 0; channel is addr if ALE rises in the same cycle, else sel_ch.
REQ-018 START falling edge in any state other than ARMED is ignored.
REQ-019 CONVERT: step counter counts 0..STEP_CYCLES-1; at terminal count the current bit is decided: trial = sar with bit idx set; sar <= trial if sample >= trial, else keep; idx decrements.
REQ-020 Decisions occur at edges F+STEP_CYCLES*k, k=1..8; decision for bit 0 at F+8*STEP_CYCLES.
REQ-021 On edge F+8*STEP_CYCLES+1: result <= sar, eoc <= 1, state <= DONE (65 cycles after F for default).
REQ-022 Final result shall equal the sampled 8-bit value exactly (unsigned compare, no rounding).
REQ-023 ch_values changes after cycle F shall not affect the conversion.
REQ-024 ALE during CONVERT updates sel_ch but not the ongoing sample.
REQ-025 eoc remains 0 from START rise through end of conversion, including while start is held high in ARMED.
REQ-026 Read path, one-cycle latency: each edge data_en <= oe; data_out <= oe ? result : 8'h00.
REQ-027 oe asserted during conversion returns the previous completed result; no conversion state changes.
REQ-028 START rise and fall both detected never occur in one cycle; a one-cycle start pulse yields rise at edge R and fall at edge R+1.

Reset
REQ-029 On reset: state IDLE, eoc=1, data_out=8'h00, data_en=0, sel_ch=0, sar=0, sample=0, result=0, counters=0, edge registers=0.
REQ-030 Reset overrides all events in the same cycle, including mid-conversion; no partial result is stored.
REQ-031 Because edge registers reset to 0, an input held high across reset release is seen as a rising edge on the first cycle after reset.

Verification
REQ-032 Assert reset 2 cycles -> eoc=1, data_en=0, data_out=8'h00, sel_ch=0.
REQ-033 ch3=8'hA5; ALE pulse addr=3; 1-cycle start pulse -> sel_ch=3, eoc=0 edge after rise, eoc=1 exactly 65 cycles after fall edge; oe=1 -> data_en=1, data_out=8'hA5 next cycle.
REQ-034 ch0=8'h00 then ch7=8'hFF conversions -> results 8'h00 and 8'hFF; 8'h80 and 8'h7F on ch1 -> exact match.
REQ-035 Second start pulse 20 cycles into conversion with ch3 changed to 8'h3C -> eoc stays 0, completes 65 cycles after second fall with 8'h3C; prior result 8'hA5 readable until then.
REQ-036 Change ch3 from 8'h55 to 8'hAA 3 cycles after fall; ALE addr=5 mid-conversion -> result 8'h55, sel_ch=5.
REQ-037 Reset 30 cycles into conversion -> next cycle eoc=1, result=8'h00; oe read returns 8'h00.
